// File: rtl/aes_cipher_iter_if.sv
// Handshake and data bundle for the iterative AES encryptor.
// Bit 0 is the MSB on every bus.
interface aes_cipher_iter_if #(
    parameter int SIZE = 128
);
    localparam int KW = 128 * 7 + (SIZE / 32) * 128;

    // valid/ready: a transfer happens on a rising edge where both are 1;
    // the source holds data stable while valid is up and ready is low.
    logic            in_valid;
    logic            in_ready;
    logic [0:127]    plaintext;
    logic [0:KW-1]   key_exp;
    logic            out_valid;
    logic            out_ready;
    logic [0:127]    ciphertext;
    logic            busy;
    logic [1:0]      dbg_state;

    modport master (
        output in_valid, plaintext, key_exp, out_ready,
        input  in_ready, out_valid, ciphertext, busy, dbg_state
    );

    modport slave (
        input  in_valid, plaintext, key_exp, out_ready,
        output in_ready, out_valid, ciphertext, busy, dbg_state
    );
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one full round per clock, NR rounds per block,
// expanded key captured at accept so the inputs may change freely afterwards.
module aes_cipher_iter #(
    parameter int SIZE = 128
) (
    input  logic              clk,
    input  logic              rst,
    aes_cipher_iter_if.slave  bus
);
    localparam int NR = 6 + SIZE / 32;
    localparam int KW = 128 * 7 + (SIZE / 32) * 128;
    localparam logic [3:0] NR4 = 4'(NR);

    if (!(SIZE == 128 || SIZE == 192 || SIZE == 256)) begin : g_bad_size
        $fatal(1, "aes_cipher_iter: SIZE must be 128, 192 or 256");
    end

    // FIPS-197 S-box, entry x at bits [8x +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [0:127]    blk_q, blk_d;
    logic [0:KW-1]   key_q, key_d;
    logic [0:127]    ct_q, ct_d;

    logic [0:127]    rk_sel;
    logic [0:127]    sr_out;
    logic [0:127]    mc_out;
    logic [0:127]    round_out;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes is bytewise, so it commutes with ShiftRows; do both in one pass.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8 * (4 * c + r) +: 8] = sbox(s[8 * (4 * ((c + r) % 4) + r) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32 * c +: 8];
            a1 = s[32 * c + 8 +: 8];
            a2 = s[32 * c + 16 +: 8];
            a3 = s[32 * c + 24 +: 8];
            o[32 * c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    always_comb begin
        rk_sel = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rnd_q == 4'(r)) begin
                rk_sel = key_q[128 * r +: 128];
            end
        end
    end

    always_comb begin
        sr_out    = sub_shift(blk_q);
        mc_out    = mix_columns(sr_out);
        round_out = ((rnd_q == NR4) ? sr_out : mc_out) ^ rk_sel;
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        key_d   = key_q;
        ct_d    = ct_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.plaintext ^ bus.key_exp[0:127];
                    key_d   = bus.key_exp;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                blk_d = round_out;
                if (rnd_q == NR4) begin
                    ct_d    = round_out;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            blk_q   <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q == ROUND) || (state_q == DONE);
    assign bus.ciphertext = ct_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: one instance per key size, checked against a
// byte-level AES model with an algebraically derived S-box.
module tb_aes_cipher_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_cipher_iter_if #(.SIZE(128)) b128 ();
    aes_cipher_iter_if #(.SIZE(192)) b192 ();
    aes_cipher_iter_if #(.SIZE(256)) b256 ();

    aes_cipher_iter #(.SIZE(128)) dut128 (.clk(clk), .rst(rst), .bus(b128));
    aes_cipher_iter #(.SIZE(192)) dut192 (.clk(clk), .rst(rst), .bus(b192));
    aes_cipher_iter #(.SIZE(256)) dut256 (.clk(clk), .rst(rst), .bus(b256));

    int checks = 0;
    int failures = 0;
    logic [7:0] sbox_m [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, s, t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv;
            t = inv;
            for (int n = 0; n < 4; n++) begin
                t = {t[6:0], t[7]};
                s ^= t;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [0:1919] ke = '0;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = key[32 * i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int i = 0; i < nw; i++) ke[32 * i +: 32] = w[i];
        return ke;
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1919] ke, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [0:127] o;
        for (int k = 0; k < 16; k++) s[k] = pt[8 * k +: 8] ^ ke[8 * k +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_m[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4 * c + row] = t[4 * ((c + row) % 4) + row];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[4 * c + i];
                    for (int i = 0; i < 4; i++)
                        s[4 * c + i] = gmul(a[i], 8'h02) ^ gmul(a[(i + 1) % 4], 8'h03)
                                     ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
                end
            end
            for (int k = 0; k < 16; k++) s[k] ^= ke[128 * r + 8 * k +: 8];
        end
        for (int k = 0; k < 16; k++) o[8 * k +: 8] = s[k];
        return o;
    endfunction

    function automatic logic [0:127] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [0:255] rand_key();
        logic [0:255] k;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [0:1919] rand_ke();
        logic [0:1919] k;
        for (int i = 0; i < 60; i++) k[32 * i +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- bus access ----------------
    function automatic logic f_in_ready(input int sz);
        case (sz)
            192: return b192.in_ready;
            256: return b256.in_ready;
            default: return b128.in_ready;
        endcase
    endfunction

    function automatic logic f_out_valid(input int sz);
        case (sz)
            192: return b192.out_valid;
            256: return b256.out_valid;
            default: return b128.out_valid;
        endcase
    endfunction

    function automatic logic f_busy(input int sz);
        case (sz)
            192: return b192.busy;
            256: return b256.busy;
            default: return b128.busy;
        endcase
    endfunction

    function automatic logic [127:0] f_ct(input int sz);
        case (sz)
            192: return b192.ciphertext;
            256: return b256.ciphertext;
            default: return b128.ciphertext;
        endcase
    endfunction

    task automatic drive(input int sz, input logic v, input logic [0:127] pt,
                         input logic [0:1919] ke, input logic ordy);
        case (sz)
            192: begin
                b192.in_valid = v; b192.plaintext = pt; b192.key_exp = ke[0:1663]; b192.out_ready = ordy;
            end
            256: begin
                b256.in_valid = v; b256.plaintext = pt; b256.key_exp = ke[0:1919]; b256.out_ready = ordy;
            end
            default: begin
                b128.in_valid = v; b128.plaintext = pt; b128.key_exp = ke[0:1407]; b128.out_ready = ordy;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One block: accept, wait for out_valid, hold out_ready low for `hold`
    // cycles, then hand off and check the return to IDLE.
    task automatic run_block(input int sz, input logic [0:127] pt, input logic [0:1919] ke,
                             input int hold, input bit noise, input logic [127:0] exp,
                             input string tag);
        int nr = sz / 32 + 6;
        int lat = 0;
        chk({tag, " ready_before_accept"}, 128'(f_in_ready(sz)), 128'(1'b1));
        drive(sz, 1'b1, pt, ke, 1'b0);
        step();
        drive(sz, 1'b0, pt, ke, 1'b0);
        while (!f_out_valid(sz) && lat < 40) begin
            if (noise)
                drive(sz, 1'($urandom_range(0, 1)), rand_blk(), rand_ke(), 1'($urandom_range(0, 1)));
            step();
            lat++;
            if (!f_out_valid(sz)) begin
                chk({tag, " in_ready_in_flight"}, 128'(f_in_ready(sz)), 128'(1'b0));
                chk({tag, " busy_in_flight"}, 128'(f_busy(sz)), 128'(1'b1));
            end
        end
        chk({tag, " latency"}, 128'(lat), 128'(nr));
        chk({tag, " ciphertext"}, f_ct(sz), exp);
        drive(sz, 1'b0, pt, ke, 1'b0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, " hold_out_valid"}, 128'(f_out_valid(sz)), 128'(1'b1));
            chk({tag, " hold_ciphertext"}, f_ct(sz), exp);
        end
        drive(sz, 1'b0, pt, ke, 1'b1);
        step();
        drive(sz, 1'b0, pt, ke, 1'b0);
        chk({tag, " ready_after_handoff"}, 128'(f_in_ready(sz)), 128'(1'b1));
        chk({tag, " out_valid_after_handoff"}, 128'(f_out_valid(sz)), 128'(1'b0));
        chk({tag, " busy_after_handoff"}, 128'(f_busy(sz)), 128'(1'b0));
        chk({tag, " ciphertext_retained"}, f_ct(sz), exp);
    endtask

    task automatic back_to_back(input int sz, input int nblk);
        int nr = sz / 32 + 6;
        logic [127:0] exp_q[$];
        logic [0:1919] ke;
        logic [0:127] pt;
        logic vld = 1'b1;
        logic prev_rdy;
        int accepts = 0, outs = 0, last_acc = -1, cyc = 0;
        ke = expand(rand_key(), sz / 32);
        pt = rand_blk();
        drive(sz, vld, pt, ke, 1'b1);
        prev_rdy = f_in_ready(sz);
        while (outs < nblk && cyc < (nblk + 2) * (nr + 2)) begin
            step();
            cyc++;
            if (prev_rdy && vld) begin
                exp_q.push_back(encrypt(pt, ke, nr));
                if (last_acc >= 0) chk("b2b accept_spacing", 128'(cyc - last_acc), 128'(nr + 2));
                last_acc = cyc;
                accepts++;
                ke = expand(rand_key(), sz / 32);
                pt = rand_blk();
                vld = (accepts < nblk);
                drive(sz, vld, pt, ke, 1'b1);
            end
            if (f_out_valid(sz)) begin
                chk("b2b queue_nonempty", 128'(exp_q.size() > 0), 128'(1'b1));
                chk("b2b ciphertext", f_ct(sz), exp_q.pop_front());
                outs++;
            end
            prev_rdy = f_in_ready(sz);
        end
        chk("b2b outputs", 128'(outs), 128'(nblk));
        step();
        drive(sz, 1'b0, pt, ke, 1'b0);
        chk("b2b idle_at_end", 128'(f_in_ready(sz)), 128'(1'b1));
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [0:127] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [0:255] k128, k192, k256, kapp;
        logic [0:1919] ke, ke128;
        logic [0:127] pt;
        int sz;

        k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kapp = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

        for (int s = 0; s < 3; s++) drive(128 + 64 * s, 1'b0, '0, '0, 1'b0);
        build_sbox();
        ke128 = expand(k128, 4);

        rst = 1'b1;
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            sz = 128 + 64 * s;
            chk($sformatf("reset%0d in_ready", sz), 128'(f_in_ready(sz)), 128'(1'b1));
            chk($sformatf("reset%0d out_valid", sz), 128'(f_out_valid(sz)), 128'(1'b0));
            chk($sformatf("reset%0d busy", sz), 128'(f_busy(sz)), 128'(1'b0));
            chk($sformatf("reset%0d ciphertext", sz), f_ct(sz), 128'h0);
        end
        rst = 1'b0;

        // Known-answer vectors, first accept right after reset release.
        run_block(128, FIPS_PT, ke128, 0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips128");
        run_block(192, FIPS_PT, expand(k192, 6), 0, 1'b0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "fips192");
        run_block(256, FIPS_PT, expand(k256, 8), 0, 1'b0, 128'h8ea2b7ca516745bfeafc49904b496089, "fips256");

        // Backpressure: out_ready low for 5 cycles.
        run_block(128, 128'h3243f6a8885a308d313198a2e0370734, expand(kapp, 4), 5, 1'b0,
                  128'h3925841d02dc09fbdc118597196a0b32, "appendix_b");

        // Input noise while the block is in flight.
        run_block(128, FIPS_PT, ke128, 2, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "noise128");

        // Reset in the middle of round 5.
        drive(128, 1'b1, FIPS_PT, ke128, 1'b0);
        step();
        drive(128, 1'b0, FIPS_PT, ke128, 1'b0);
        repeat (4) step();
        chk("abort busy_before_rst", 128'(f_busy(128)), 128'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort out_valid", 128'(f_out_valid(128)), 128'(1'b0));
        chk("abort busy", 128'(f_busy(128)), 128'(1'b0));
        chk("abort in_ready", 128'(f_in_ready(128)), 128'(1'b1));
        chk("abort ciphertext_cleared", f_ct(128), 128'h0);
        run_block(128, FIPS_PT, ke128, 0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "after_abort");

        back_to_back(128, 4);
        back_to_back(256, 3);

        // Random keys and blocks on every size.
        for (int s = 0; s < 3; s++) begin
            sz = 128 + 64 * s;
            for (int n = 0; n < 4; n++) begin
                ke = expand(rand_key(), sz / 32);
                pt = rand_blk();
                run_block(sz, pt, ke, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                          encrypt(pt, ke, sz / 32 + 6), $sformatf("rand%0d_%0d", sz, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
- REQ-001: The block SHALL have parameter SIZE, default 128, giving the cipher key length in bits; legal values are 128, 192 and 256.
- REQ-002: The block SHALL have a derived constant NR = 6 + SIZE/32, the round count (10, 12 or 14).
- REQ-003: The block SHALL have one clock; reset is synchronous and active-high.
- REQ-004: Ports, bit 0 = MSB on all buses:
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous, active-high reset
  - in_valid  in  1  plaintext and key_exp are presented
  - in_ready  out  1  block can accept a new block
  - plaintext  in  [0:127]  input block
  - key_exp  in  [0:128*7+(SIZE/32)*128-1]  expanded key; round key r = key_exp[128r +: 128], r = 0..NR
  - out_valid  out  1  ciphertext is valid
  - out_ready  in  1  consumer accepts ciphertext
  - ciphertext  out  [0:127]  output block
  - busy  out  1  a block is in flight (state ROUND or DONE)

Function
- REQ-005: State byte k (k = 0..15) SHALL be bits [8k:8k+7]; column c SHALL be bytes 4c..4c+3, per FIPS-197 column-major input order.
- REQ-006: The FSM SHALL have three states: IDLE, ROUND and DONE.
- REQ-007: in_ready SHALL be 1 only in IDLE; an accept is in_valid & in_ready at a rising edge.
- REQ-008: On accept, the block SHALL register state = plaintext ^ rk0, capture all of key_exp internally, set round counter rnd = 1, and go to ROUND.
- REQ-009: After an accept, later changes on plaintext and key_exp SHALL NOT affect the block in flight.
- REQ-010: In ROUND, each edge SHALL apply, in order, SubBytes (FIPS-197 S-box), ShiftRows (row i rotated left by i), MixColumns and AddRoundKey with rk[rnd], then increment rnd.
- REQ-011: When rnd == NR, the round SHALL omit MixColumns, load the result into the ciphertext register, and go to DONE.
- REQ-012: MixColumns SHALL use GF(2^8) multiply by 02 as a 1-bit left shift, XORed with 8'h1b when the shifted-out MSB is 1; multiply by 03 = (02·x) ^ x.
- REQ-013: rnd SHALL be 4 bits wide and SHALL NOT wrap within an operation.
- REQ-014: Latency: out_valid SHALL rise exactly NR edges after the accepting edge (10/12/14 cycles).
- REQ-015: In DONE, out_valid SHALL be 1 and ciphertext SHALL be held stable until out_ready = 1.
- REQ-016: On out_valid & out_ready, the FSM SHALL return to IDLE and in_ready SHALL be 1 on the next cycle.
- REQ-017: Throughput SHALL be one block per NR+2 cycles at best, with no overlap of blocks.
- REQ-018: in_valid asserted while in ROUND or DONE SHALL be ignored and SHALL NOT corrupt the block in flight.
- REQ-019: out_ready asserted while not in DONE SHALL have no effect.
- REQ-020: ciphertext SHALL retain its last value after the DONE→IDLE transition until the next DONE.
- REQ-021: A SIZE value other than 128, 192 or 256 SHALL fail elaboration.

Reset
- REQ-022: When rst = 1 at an edge, the block SHALL force state IDLE, in_ready = 1, out_valid = 0, busy = 0, rnd = 0, ciphertext = 128'h0 and the internal state register = 0.
- REQ-023: rst SHALL take priority over every handshake.
- REQ-024: rst asserted during ROUND or DONE SHALL abort the block with no output; in the same cycle, out_valid = 0 is visible on the next edge.
- REQ-025: After rst deasserts, the first accept SHALL be possible in the immediately following cycle.

Verification
- REQ-026: SIZE = 128, key 000102..0f (key_exp = its FIPS-197 expansion), plaintext 00112233445566778899aabbccddeeff, out_ready = 1 -> out_valid rises 10 edges after accept, ciphertext = 69c4e0d86a7b0430d8cdb78070b4c55a.
- REQ-027: SIZE = 192, key 000102..17, same plaintext -> out_valid after 12 edges, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191; SIZE = 256, key 000102..1f -> out_valid after 14 edges, ciphertext 8ea2b7ca516745bfeafc49904b496089.
- REQ-028: SIZE = 128, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles -> ciphertext 3925841d02dc09fbdc118597196a0b32, held stable with out_valid = 1 for all 5 cycles; in_ready = 1 exactly one cycle after the out_ready handshake.
- REQ-029: in_valid toggled and plaintext/key_exp randomized during ROUND -> result unchanged from REQ-026 and in_ready = 0 throughout.
- REQ-030: rst pulsed at round 5 -> next cycle out_valid = 0, busy = 0, in_ready = 1; a following REQ-026 stimulus completes correctly.
- REQ-031: Back-to-back blocks with in_valid and out_ready held 1 -> accepts exactly NR+2 cycles apart, each ciphertext correct.
